// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared memory bus: grants one access at a
// time and sequences the MAR/MDR/CS/R_NW strobes for a read or write on sysbus.
module mem_bus_arbiter #(
  parameter  int WORD_W = 8,
  parameter  int OP_W   = 3,
  localparam int A_W    = WORD_W - OP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [A_W-1:0]    addr0,
  input  logic [A_W-1:0]    addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              load_MAR,
  output logic              load_MDR,
  output logic              MDR_bus,
  output logic              CS,
  output logic              R_NW,
  output logic [2:0]        dbg_state,
  inout  wire  [WORD_W-1:0] sysbus
);

  // Handshake: a requester raises reqN with addr/wdata/we stable and holds it until
  // ackN pulses for one cycle; request fields are captured at grant, so later changes
  // are ignored, and a req dropped before it is granted is simply never served.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_RD_LOAD   = 3'd2,
    S_RD_BUS    = 3'd3,
    S_WR_DATA   = 3'd4,
    S_WR_COMMIT = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic [A_W-1:0]      addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_flag_q, err_flag_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic                bus_en;
  logic [WORD_W-1:0]   bus_val;
  logic                pick;

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      err_flag_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      err_flag_q   <= err_flag_d;
      rdata_q      <= rdata_d;
    end
  end

  // Tie goes to whoever was not served last, which yields strict alternation.
  always_comb begin
    if (req0 && req1) pick = ~last_grant_q;
    else              pick = req1;
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    err_flag_d   = err_flag_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d      = pick;
          last_grant_d = pick;
          addr_d       = pick ? addr1  : addr0;
          wdata_d      = pick ? wdata1 : wdata0;
          we_d         = pick ? we1    : we0;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!we_q) begin
          state_d = S_RD_LOAD;
        end else if (addr_q[A_W-1]) begin
          state_d = S_WR_DATA;
        end else begin
          // Low half of the address space is ROM: refuse the write without touching memory.
          err_flag_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_RD_LOAD: state_d = S_RD_BUS;
      S_RD_BUS: begin
        rdata_d = sysbus;
        state_d = S_DONE;
      end
      S_WR_DATA:   state_d = S_WR_COMMIT;
      S_WR_COMMIT: state_d = S_DONE;
      S_DONE: begin
        err_flag_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    MDR_bus  = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b1;
    ack0     = 1'b0;
    ack1     = 1'b0;
    err      = 1'b0;
    bus_en   = 1'b0;
    bus_val  = '0;
    case (state_q)
      S_ADDR: begin
        load_MAR = 1'b1;
        bus_en   = 1'b1;
        bus_val  = {{OP_W{1'b0}}, addr_q};
      end
      S_RD_LOAD: begin
        CS       = 1'b1;
        load_MDR = 1'b1;
      end
      S_RD_BUS: begin
        CS      = 1'b1;
        MDR_bus = 1'b1;
      end
      S_WR_DATA: begin
        CS       = 1'b1;
        R_NW     = 1'b0;
        load_MDR = 1'b1;
        bus_en   = 1'b1;
        bus_val  = wdata_q;
      end
      S_WR_COMMIT: begin
        CS   = 1'b1;
        R_NW = 1'b0;
      end
      S_DONE: begin
        ack0 = ~grant_q;
        ack1 = grant_q;
        err  = err_flag_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;
  assign sysbus    = bus_en ? bus_val : {WORD_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: bus-level ROM/RAM model, per-cycle strobe checks and a
// scoreboard of expected {err, rdata} popped on each ack.
module tb_mem_bus_arbiter;

  localparam int WORD_W = 8;
  localparam int OP_W   = 3;
  localparam int A_W    = WORD_W - OP_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [A_W-1:0]    addr0 = '0, addr1 = '0;
  logic [WORD_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              we0 = 1'b0, we1 = 1'b0;
  logic              ack0, ack1, err, busy;
  logic [WORD_W-1:0] rdata;
  logic              load_MAR, load_MDR, MDR_bus, CS, R_NW;
  logic [2:0]        dbg_state;
  wire  [WORD_W-1:0] sysbus;

  pullup (sysbus);

  mem_bus_arbiter #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
    .load_MAR(load_MAR), .load_MDR(load_MDR), .MDR_bus(MDR_bus), .CS(CS), .R_NW(R_NW),
    .dbg_state(dbg_state), .sysbus(sysbus)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // memory model driven purely by the strobes
  logic [WORD_W-1:0] mem_arr [32];
  logic [WORD_W-1:0] ref_mem [32];
  logic [A_W-1:0]    mar = '0;
  logic [WORD_W-1:0] mdr = '0;

  assign sysbus = MDR_bus ? mdr : {WORD_W{1'bz}};

  always @(posedge clock) begin
    if (load_MAR) mar <= sysbus[A_W-1:0];
    if (load_MDR) mdr <= R_NW ? mem_arr[mar] : sysbus;
    if (CS && !R_NW && !load_MDR) mem_arr[mar] <= mdr;
  end

  // scoreboard
  logic [8:0]        exp_q[$];
  logic [WORD_W-1:0] last_rdata = '0;
  int                n_vec = 0;
  int                n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // {load_MAR, load_MDR, MDR_bus, CS, R_NW, busy, ack0, ack1, err}
  function automatic logic [8:0] exp_vec(input int kind, input int i, input int who);
    logic lm, ld, mb, cs, rnw, bz, a0, a1, e;
    int   last;
    lm = 0; ld = 0; mb = 0; cs = 0; rnw = 1; bz = 1; a0 = 0; a1 = 0; e = 0;
    last = (kind == 2) ? 2 : 4;
    if (i == 0) bz = 0;
    else if (i == 1) lm = 1;
    else if (i == last) begin
      a0 = (who == 0); a1 = (who == 1); e = (kind == 2);
    end else if (kind == 0) begin
      cs = 1;
      if (i == 2) ld = 1; else mb = 1;
    end else begin
      cs = 1; rnw = 0;
      if (i == 2) ld = 1;
    end
    return {lm, ld, mb, cs, rnw, bz, a0, a1, e};
  endfunction

  function automatic logic [WORD_W-1:0] exp_bus(input int kind, input int i,
      input logic [A_W-1:0] a, input logic [WORD_W-1:0] d, input logic [WORD_W-1:0] mv);
    logic [WORD_W-1:0] v;
    v = 8'hFF;
    if (i == 1) v = {3'b000, a};
    else if (kind == 1 && i == 2) v = d;
    else if (kind == 0 && i == 3) v = mv;
    return v;
  endfunction

  function automatic logic [8:0] dut_vec();
    return {load_MAR, load_MDR, MDR_bus, CS, R_NW, busy, ack0, ack1, err};
  endfunction

  // driver tasks
  task automatic set_req(input int who, input logic v, input logic we,
                         input logic [A_W-1:0] a, input logic [WORD_W-1:0] d);
    if (who == 0) begin
      req0 = v; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = v; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " strobes"}, dut_vec(), exp_vec(0, 0, 0));
    chk({tag, " sysbus"}, sysbus, 8'hFF);
  endtask

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic access(input int who, input logic we, input logic [A_W-1:0] a,
                        input logic [WORD_W-1:0] d);
    int                kind, last;
    logic [WORD_W-1:0] rv;
    logic [8:0]        expv;
    kind = !we ? 0 : (a[A_W-1] ? 1 : 2);
    last = (kind == 2) ? 2 : 4;
    rv   = ref_mem[a];
    if (kind == 0) last_rdata = rv;
    if (kind == 1) ref_mem[a] = d;
    exp_q.push_back({kind == 2, last_rdata});
    set_req(who, 1'b1, we, a, d);
    for (int i = 1; i <= last; i++) begin
      @(negedge clock);
      chk($sformatf("strobes req%0d k%0d c%0d", who, kind, i), dut_vec(), exp_vec(kind, i, who));
      chk($sformatf("sysbus req%0d k%0d c%0d", who, kind, i), sysbus, exp_bus(kind, i, a, d, rv));
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) chk("unexpected ack", 32'd1, 32'd0);
        else begin
          expv = exp_q.pop_front();
          chk($sformatf("err_rdata req%0d addr%0d", who, a), {err, rdata}, expv);
        end
      end
    end
    set_req(who, 1'b0, we, a, d);
    @(negedge clock);
    check_idle("post-ack idle");
  endtask

  int               k;
  int               cyc;
  int               order [4];
  logic [8:0]       expv;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_arr[i] = WORD_W'((i * 29) ^ 8'h33);
      if (i == 2) mem_arr[i] = 8'h5E;
      ref_mem[i] = mem_arr[i];
    end

    // reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_idle("reset");
    chk("reset rdata", rdata, 8'h00);
    chk("reset state", dbg_state, 3'd0);

    // directed accesses
    access(0, 1'b0, 5'd2, 8'h00);
    access(1, 1'b1, 5'd17, 8'hA5);
    access(0, 1'b0, 5'd17, 8'h00);
    access(0, 1'b1, 5'd3, 8'h77);
    access(1, 1'b0, 5'd3, 8'h00);
    access(1, 1'b1, 5'd31, 8'h3C);
    access(1, 1'b0, 5'd31, 8'h00);

    // random accesses
    for (int n = 0; n < 10; n++)
      access($urandom_range(0, 1), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));

    // round-robin with both requesters held from reset
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_rdata = '0;
    order = '{0, 1, 0, 1};
    set_req(0, 1'b1, 1'b0, 5'd2, 8'h00);
    set_req(1, 1'b1, 1'b0, 5'd17, 8'h00);
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back({1'b0, ref_mem[2]});
      exp_q.push_back({1'b0, ref_mem[17]});
    end
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      chk("ack overlap", {31'd0, ack0 & ack1}, 32'd0);
      if (ack0 || ack1) begin
        chk($sformatf("rr order %0d", k), {31'd0, ack1}, order[k]);
        chk($sformatf("rr cycle %0d", k), cyc, 4 + 5 * k);
        if (exp_q.size() != 0) begin
          expv = exp_q.pop_front();
          chk($sformatf("rr data %0d", k), {err, rdata}, expv);
        end
        k++;
        if (k == 4) begin
          set_req(0, 1'b0, 1'b0, 5'd2, 8'h00);
          set_req(1, 1'b0, 1'b0, 5'd17, 8'h00);
        end
      end
    end
    chk("rr ack count", k, 4);
    set_req(0, 1'b0, 1'b0, 5'd2, 8'h00);
    set_req(1, 1'b0, 1'b0, 5'd17, 8'h00);
    @(negedge clock);
    check_idle("rr idle");

    // reset pulsed during RD_LOAD aborts the read
    set_req(0, 1'b1, 1'b0, 5'd17, 8'h00);
    @(negedge clock);
    chk("abort c1 strobes", dut_vec(), exp_vec(0, 1, 0));
    @(negedge clock);
    chk("abort c2 strobes", dut_vec(), exp_vec(0, 2, 0));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_rdata = '0;
    check_idle("abort");
    chk("abort rdata", rdata, 8'h00);
    chk("abort state", dbg_state, 3'd0);
    access(0, 1'b0, 5'd17, 8'h00);

    // final report
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the processor's single memory bus (sysbus plus the MAR/MDR control strobes) between two requesters: req 0 is the CPU sequencer, req 1 is the loader/decryptor engine.
- Arbitrates round-robin, then runs a fixed multi-cycle read or write sequence on sysbus.
- Address MSB selects ROM (0) or RAM (1); the ROM region is read-only.
- Sits between the requesters and the rom/ram blocks, and is the only driver of load_MAR, load_MDR, MDR_bus, CS and R_NW.

Parameters:
- WORD_W, 8, bus/data width.
- OP_W, 3, opcode width; memory address width is A_W = WORD_W-OP_W (5).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  access request; held high until the matching ack.
- addr0, addr1  in  A_W each  word address.
- wdata0, wdata1  in  WORD_W each  write data.
- we0, we1  in  1 each  1 = write, 0 = read.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = rejected write to ROM region.
- rdata  out  WORD_W  read data, valid with ack, held until the next ack.
- busy  out  1  high in every state except IDLE.
- load_MAR, load_MDR, MDR_bus, CS, R_NW  out  1 each  memory control strobes.
- sysbus  inout  WORD_W  shared bus; this block drives it only in ADDR and WR_DATA, and leaves it high-Z otherwise.

Behaviour:
- Reset (synchronous, sampled at clock edge):
  - state=IDLE; last_grant=1, so req0 wins the first tie.
  - All strobes 0; R_NW=1; ack0/ack1/err=0; rdata=0; busy=0; sysbus high-Z.
  - Reset asserted mid-sequence aborts the access at the next edge with no ack.
- States: IDLE, ADDR, RD_LOAD, RD_BUS, WR_DATA, WR_COMMIT, DONE.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both: grant the requester that is not last_grant.
  - On grant: latch addr/wdata/we of the winner, update last_grant, go to ADDR.
- ADDR: sysbus = zero-extended addr; load_MAR=1.
  - Read: go to RD_LOAD.
  - Write with addr[A_W-1]=1: go to WR_DATA.
  - Write with addr[A_W-1]=0: set err flag, go to DONE. No CS, no load_MDR.
- RD_LOAD: CS=1, R_NW=1, load_MDR=1. Go to RD_BUS.
- RD_BUS: MDR_bus=1, CS=1, R_NW=1; rdata <= sysbus at the clock edge. Go to DONE.
- WR_DATA: sysbus = latched wdata; CS=1, R_NW=0, load_MDR=1. Go to WR_COMMIT.
- WR_COMMIT: CS=1, R_NW=0, sysbus high-Z. Go to DONE.
- DONE: ack of the granted requester = 1; err = flag. Go to IDLE and clear the flag.
- R_NW=1 in all states other than WR_DATA and WR_COMMIT.
- Latency, with req sampled in IDLE at cycle 0:
  - Read or RAM write: ack at cycle 4.
  - ROM-region write: ack with err=1 at cycle 2.
  - Earliest next grant is the IDLE cycle after ack.
- Requester rule: drop req or present a new request in the cycle after ack.
  - A req dropped before it is granted is ignored.
  - req/addr changes after grant are ignored (values are latched).
- Round-robin: under continuous requests from both sides, grants strictly alternate 0,1,0,1.
- A request arriving while busy waits; it is not lost as long as it is held.
- Only one ack is high in any cycle; ack and err are never high outside DONE.

Test Plan:
- Reset, then req0 read addr0=5'd2 with ROM word 2 = 8'h5E → load_MAR at cycle 1 with sysbus=8'h02; ack0 at cycle 4; rdata=8'h5E; err=0.
- req1 write addr1=5'd17, wdata1=8'hA5 → WR_DATA drives sysbus=8'hA5 with load_MDR=1 and R_NW=0; ack1 at cycle 4; a following read of 17 returns 8'hA5.
- req0 write addr0=5'd3 (ROM region) → ack0 with err=1 at cycle 2; CS and load_MDR never asserted; a re-read of address 3 is unchanged.
- req0 and req1 both held continuously from reset → grant order 0,1,0,1; each ack 5 cycles apart; acks never coincide.
- Reset pulsed in RD_LOAD → next cycle IDLE, all strobes 0, no ack; a re-issued request completes normally.
- sysbus check in every state: high-Z outside ADDR and WR_DATA; no contention during RD_BUS.
